bitgen_datapath_ctrl: RTL and testbench

//   Inverse of the lab bit counter: takes a ones-count N and serially builds a WIDTH-bit

---
 rtl/bitgen_datapath_ctrl.sv | 73 +++++++
 tb/tb_bitgen_datapath_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bitgen_datapath_ctrl.sv
// Serial thermometer-code generator: builds a WIDTH-bit word holding exactly N ones, one bit per clock.
// Optional BITGEN_MSB_FIRST_EN fills the ones from the MSB instead of the LSB.
module bitgen_datapath_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)+1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          over_range;

  assign over_range = (count_in > WIDTH_C);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FILL;
            cnt    <= over_range ? WIDTH_C : count_in;
            result <= '0;
            error  <= over_range;
          end
        end
        S_FILL: begin
          // cnt is clamped to WIDTH on entry, so the shift never wraps past a full word.
          if (cnt != '0) begin
`ifdef BITGEN_MSB_FIRST_EN
            result <= {1'b1, result[WIDTH-1:1]};
`else
            result <= {result[WIDTH-2:0], 1'b1};
`endif
            cnt    <= cnt - ONE_C;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // start must drop for one edge before a new request can be accepted.
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_FILL);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_bitgen_datapath_ctrl.sv
// Self-checking bench for bitgen_datapath_ctrl (WIDTH=8): directed cases, a sweep and random requests
// compared against a thermometer-code model of the expected word, error flag and latency.
module tb_bitgen_datapath_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1)+1;

  logic             clock;
  logic             reset;
  logic             start;
  logic [CW-1:0]    count_in;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             error;

  int checks   = 0;
  int failures = 0;

  bitgen_datapath_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .count_in (count_in),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word with j ones packed against the fill end of the register.
  function automatic logic [31:0] exp_word(input int j);
    int k;
    logic [31:0] mask;
    k = (j > WIDTH) ? WIDTH : j;
    mask = (32'd1 << k) - 32'd1;
`ifdef BITGEN_MSB_FIRST_EN
    return (mask << (WIDTH - k)) & ((32'd1 << WIDTH) - 32'd1);
`else
    return mask;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full request: accept, fill, done, optional hold in done, return to idle.
  task automatic run(input int n, input bit noisy, input int hold);
    int neff;
    int edges;
    logic [31:0] final_word;
    neff  = (n > WIDTH) ? WIDTH : n;
    edges = 0;
    final_word = exp_word(neff);

    start    = 1'b1;
    count_in = CW'(n);
    step();
    check("accept_busy",   {31'd0, busy},   32'd1);
    check("accept_done",   {31'd0, done},   32'd0);
    check("accept_result", {24'd0, result}, 32'd0);
    check("accept_error",  {31'd0, error},  {31'd0, n > WIDTH});
    start = 1'b0;

    while (!done && edges < 40) begin
      if (noisy) begin
        start    = 1'($urandom);
        count_in = CW'($urandom);
      end
      step();
      edges++;
      if (!done) begin
        check("fill_result", {24'd0, result}, exp_word(edges));
        check("fill_busy",   {31'd0, busy},   32'd1);
      end
    end

    check("latency",     edges,            neff + 1);
    check("done_result", {24'd0, result},  final_word);
    check("done_error",  {31'd0, error},   {31'd0, n > WIDTH});
    check("done_busy",   {31'd0, busy},    32'd0);

    if (hold > 0) start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_done",   {31'd0, done},   32'd1);
      check("hold_result", {24'd0, result}, final_word);
    end

    start = 1'b0;
    step();
    check("idle_done",   {31'd0, done},   32'd0);
    check("idle_busy",   {31'd0, busy},   32'd0);
    check("idle_result", {24'd0, result}, final_word);
    check("idle_error",  {31'd0, error},  {31'd0, n > WIDTH});
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    count_in = '0;
    #12;
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_busy",   {31'd0, busy},   32'd0);
    check("reset_done",   {31'd0, done},   32'd0);
    check("reset_error",  {31'd0, error},  32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // Directed cases.
    run(5, 1'b0, 0);
    run(0, 1'b0, 0);
    run(8, 1'b0, 0);
    run(12, 1'b0, 5);
    run(2, 1'b0, 0);
    run(6, 1'b1, 0);
    run(12, 1'b1, 2);

    // Idle stays idle and holds everything without start.
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_hold_done",   {31'd0, done},   32'd0);
      check("idle_hold_result", {24'd0, result}, exp_word(8));
      check("idle_hold_error",  {31'd0, error},  32'd1);
    end

    // Asynchronous reset in idle clears the held error and word.
    #2 reset = 1'b1;
    #1;
    check("rst_idle_error",  {31'd0, error},  32'd0);
    check("rst_idle_result", {24'd0, result}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Reset mid-fill after three shifts of N=6.
    start    = 1'b1;
    count_in = CW'(6);
    step();
    start = 1'b0;
    repeat (3) step();
    check("pre_abort_result", {24'd0, result}, exp_word(3));
    #2 reset = 1'b1;
    #1;
    check("abort_result", {24'd0, result}, 32'd0);
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_done",   {31'd0, done},   32'd0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_done", {31'd0, done}, 32'd0);

    // Sweep every count including out-of-range ones.
    for (int n = 0; n < 16; n++) run(n, 1'b0, 0);

    // Random requests over the full count_in range.
    for (int i = 0; i < 20; i++) begin
      run(int'($urandom_range(0, (1 << CW) - 1)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
